// File: rtl/i2c_txff.sv
// I2C transmit FIFO: APB pushes bytes, the I2C shifter pops them (FWFT head).
// Ports: pclk/prst_n, apb_ctx clear, apb_txff_wr/din push, i_txff_rd pop, status out.
module i2c_txff #(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int LWM = 4
) (
  input  logic          pclk,
  input  logic          prst_n,
  input  logic          apb_ctx,
  input  logic          apb_txff_wr,
  input  logic [DW-1:0] apb_txff_din,
  input  logic          i_txff_rd,
  output logic [DW-1:0] txff_data,
  output logic          txff_txe,
  output logic          txff_full,
  output logic [AW:0]   txff_lvl,
  output logic          txff_lwm,
  output logic          txff_ov,
  output logic          txff_ud
);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [DW-1:0] mem [2**AW];
  logic          apb_ctx1;
  logic          clr;
  logic          empty;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // Only the rising edge of the clear bit flushes.
  assign clr   = apb_ctx & ~apb_ctx1;
  assign wr_ok = apb_txff_wr & ~full & ~clr;
  assign rd_ok = i_txff_rd & ~empty & ~clr;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      apb_ctx1 <= 1'b0;
      txff_ov  <= 1'b0;
      txff_ud  <= 1'b0;
    end else begin
      apb_ctx1 <= apb_ctx;
      if (clr) begin
        wptr    <= '0;
        rptr    <= '0;
        txff_ov <= 1'b0;
        txff_ud <= 1'b0;
      end else begin
        if (wr_ok)
          wptr <= wptr + (AW+1)'(1);
        if (rd_ok)
          rptr <= rptr + (AW+1)'(1);
        if (apb_txff_wr & full)
          txff_ov <= 1'b1;
        if (i_txff_rd & empty)
          txff_ud <= 1'b1;
      end
    end
  end

  // Storage is not reset; emptiness masks stale contents.
  always_ff @(posedge pclk) begin
    if (wr_ok)
      mem[wptr[AW-1:0]] <= apb_txff_din;
  end

  assign txff_txe  = empty;
  assign txff_full = full;
  assign txff_lvl  = wptr - rptr;
  assign txff_lwm  = (txff_lvl <= (AW+1)'(LWM));
  assign txff_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_i2c_txff.sv
// Self-checking bench for i2c_txff against a queue-based reference model.
// Directed scenarios followed by randomized traffic and a mid-run async reset.
module tb_i2c_txff;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int DEP = 16;
  localparam int LWM = 4;

  logic          pclk;
  logic          prst_n;
  logic          apb_ctx;
  logic          apb_txff_wr;
  logic [DW-1:0] apb_txff_din;
  logic          i_txff_rd;
  logic [DW-1:0] txff_data;
  logic          txff_txe;
  logic          txff_full;
  logic [AW:0]   txff_lvl;
  logic          txff_lwm;
  logic          txff_ov;
  logic          txff_ud;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q [$];
  bit         m_ov;
  bit         m_ud;
  bit         m_ctx1;

  i2c_txff #(.DW(DW), .AW(AW), .LWM(LWM)) dut (
    .pclk         (pclk),
    .prst_n       (prst_n),
    .apb_ctx      (apb_ctx),
    .apb_txff_wr  (apb_txff_wr),
    .apb_txff_din (apb_txff_din),
    .i_txff_rd    (i_txff_rd),
    .txff_data    (txff_data),
    .txff_txe     (txff_txe),
    .txff_full    (txff_full),
    .txff_lvl     (txff_lvl),
    .txff_lwm     (txff_lwm),
    .txff_ov      (txff_ov),
    .txff_ud      (txff_ud)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ":lvl"},  int'(txff_lvl),  sz);
    chk({tag, ":txe"},  int'(txff_txe),  int'(sz == 0));
    chk({tag, ":full"}, int'(txff_full), int'(sz == DEP));
    chk({tag, ":lwm"},  int'(txff_lwm),  int'(sz <= LWM));
    chk({tag, ":data"}, int'(txff_data), (sz == 0) ? 0 : int'(q[0]));
    chk({tag, ":ov"},   int'(txff_ov),   int'(m_ov));
    chk({tag, ":ud"},   int'(txff_ud),   int'(m_ud));
  endtask

  task automatic model_reset();
    q.delete();
    m_ov   = 1'b0;
    m_ud   = 1'b0;
    m_ctx1 = 1'b0;
  endtask

  // One clock: apply inputs, step the model, check 1 time unit after the edge.
  task automatic cyc(input bit wr, input logic [7:0] din,
                     input bit rd, input bit ctx, input string tag);
    bit was_full;
    bit was_empty;
    apb_txff_wr  = wr;
    apb_txff_din = din;
    i_txff_rd    = rd;
    apb_ctx      = ctx;
    @(posedge pclk);
    was_full  = (q.size() == DEP);
    was_empty = (q.size() == 0);
    if (ctx && !m_ctx1) begin
      q.delete();
      m_ov = 1'b0;
      m_ud = 1'b0;
    end else begin
      if (wr && was_full)  m_ov = 1'b1;
      if (rd && was_empty) m_ud = 1'b1;
      if (rd && !was_empty) void'(q.pop_front());
      if (wr && !was_full)  q.push_back(din);
    end
    m_ctx1 = ctx;
    #1;
    check_all(tag);
  endtask

  task automatic flush();
    cyc(0, 8'h00, 0, 1, "flush_hi");
    cyc(0, 8'h00, 0, 0, "flush_lo");
  endtask

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'h7E;
    prst_n       = 1'b0;
    apb_ctx      = 1'b0;
    apb_txff_wr  = 1'b0;
    apb_txff_din = '0;
    i_txff_rd    = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge pclk);
    prst_n = 1'b1;
    cyc(0, 8'h00, 0, 0, "idle");
    chk("idle_data_zero", int'(txff_data), 0);

    for (int i = 0; i < 3; i++)
      cyc(1, seq[i], 0, 0, "t2_wr");
    chk("t2_lvl3", int'(txff_lvl), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_head", int'(txff_data), int'(seq[i]));
      cyc(0, 8'h00, 1, 0, "t2_rd");
    end
    chk("t2_txe", int'(txff_txe), 1);

    for (int i = 0; i < DEP; i++)
      cyc(1, 8'(i), 0, 0, "t3_fill");
    chk("t3_full", int'(txff_full), 1);
    cyc(1, 8'hFF, 0, 0, "t3_ovf");
    chk("t3_ov", int'(txff_ov), 1);
    for (int i = 0; i < DEP; i++) begin
      chk("t3_order", int'(txff_data), i);
      cyc(0, 8'h00, 1, 0, "t3_drain");
    end
    flush();

    for (int i = 0; i < DEP; i++)
      cyc(1, 8'(8'h40 + i), 0, 0, "t4_fill");
    cyc(1, 8'h55, 1, 0, "t4_wrrd_full");
    chk("t4_lvl15", int'(txff_lvl), 15);
    for (int i = 0; i < 15; i++)
      cyc(0, 8'h00, 1, 0, "t4_drain");
    flush();
    for (int i = 0; i < 10; i++)
      cyc(1, 8'(8'h80 + i), 0, 0, "t4_w1");
    for (int i = 0; i < 10; i++)
      cyc(0, 8'h00, 1, 0, "t4_r1");
    for (int i = 0; i < 12; i++)
      cyc(1, 8'(8'hC0 + i), 0, 0, "t4_wrap_w");
    for (int i = 0; i < 12; i++)
      cyc(0, 8'h00, 1, 0, "t4_wrap_r");

    cyc(0, 8'h00, 1, 0, "t5_ud");
    chk("t5_ud_flag", int'(txff_ud), 1);
    cyc(1, 8'h99, 1, 0, "t5_wr_rd_empty");
    chk("t5_data99", int'(txff_data), 8'h99);
    flush();

    for (int i = 0; i < DEP; i++)
      cyc(1, 8'(i + 1), 0, 0, "t6_fill");
    cyc(1, 8'hEE, 0, 0, "t6_ov");
    for (int i = 0; i < 11; i++)
      cyc(0, 8'h00, 1, 0, "t6_pop");
    chk("t6_lvl5", int'(txff_lvl), 5);
    cyc(1, 8'h11, 0, 1, "t6_clr_wr");
    chk("t6_clr_txe", int'(txff_txe), 1);
    cyc(1, 8'h22, 0, 1, "t6_ctx_held");
    chk("t6_data22", int'(txff_data), 8'h22);
    cyc(0, 8'h00, 0, 0, "t6_ctx_lo");

    for (int i = 0; i < 800; i++) begin
      bit          wr, rd, cx;
      int unsigned bias;
      bias = (i / 100) % 3;
      wr = ($urandom_range(99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50)));
      rd = ($urandom_range(99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50)));
      cx = ($urandom_range(99) < 3);
      cyc(wr, 8'($urandom), rd, cx, "rand");
      if (i == 400) begin
        #2;
        prst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge pclk);
        prst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
